ysyx_23060201_lsu: RTL and testbench

Parametrised load/store unit between the EXU and the data memory port, replacing the single-cycle combinational memory access with a handshaked, multi-cycle transaction. Accepts one load or store per request from the EXU, aligns data onto a DATA_WIDTH-wide bus with byte strobes, waits for the memory response under a timeout watchdog, and returns sign/zero-extended load data or an error. One transaction is in flight at a time.

---
 rtl/ysyx_23060201_lsu.sv | 211 +++++++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201_lsu: handshaked load/store unit between the EXU and the data memory port.
//   Accepts one load/store per request, drives an aligned bus request with byte strobes,
//   waits for the memory response under a timeout watchdog, then returns extended load
//   data (or an error) to the EXU. One transaction in flight at a time.
// Latency: 3 cycles minimum (accept -> bus request -> bus response -> EXU response);
//   illegal-size / trapped-misaligned requests respond the cycle after acceptance.
// Backpressure: req_ready is high only in IDLE; the bus request is held stable until
//   bus_ready, and the response is held stable until rsp_ready.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req_* / rsp_*            EXU request (valid/ready) and response (valid/ready)
//   bus_* (out)              memory request: addr aligned to the bus width, lane-shifted
//                            wdata, byte strobes (all zero for loads)
//   bus_rvalid/rdata/err     memory response, only sampled while waiting for it
// Parameters: DATA_WIDTH (32 or 64), ADDR_WIDTH, TIMEOUT (>=1 wait cycles before error).
// Build option: YSYX_23060201_LSU_MISALIGN_TRAP_EN -- when defined, a misaligned request
//   is answered with an error and no bus transaction; otherwise the address is aligned
//   down to the access size and the access proceeds normally.

module ysyx_23060201_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic                    bus_wen,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  // ---------------- request decode (IDLE only) ----------------
  logic [3:0]            req_mask;      // (2^size)-1: offset bits that must be zero
  logic                  req_illegal;
  logic [ADDR_WIDTH-1:0] req_addr_aligned;

  assign req_mask         = (4'd1 << req_size) - 4'd1;
  assign req_illegal      = (DATA_WIDTH == 32) && (req_size == 2'd3);
  assign req_addr_aligned = req_addr & ~ADDR_WIDTH'(req_mask);

`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
  logic req_misalign;
  assign req_misalign = |(4'(req_addr[OFF_W-1:0]) & req_mask);
`endif

  // ---------------- lane steering from latched fields ----------------
  logic [OFF_W-1:0]      off;
  logic [OFF_W+2:0]      shamt;         // 8 * byte offset
  logic [7:0]            strb8;
  logic [STRB_W-1:0]     strb_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign;
  logic [DATA_WIDTH-1:0] rd_ext;

  assign off      = addr_q[OFF_W-1:0];
  assign shamt    = {off, 3'b000};
  assign wdata_sh = wdata_q << shamt;
  assign rd_shift = bus_rdata >> shamt;
  assign strb_sh  = strb8[STRB_W-1:0] << off;

  always_comb begin
    strb8 = 8'hFF;
    keep  = '1;
    sign  = 1'b0;
    case (size_q)
      2'd0: begin strb8 = 8'h01; keep = DATA_WIDTH'(8'hFF);         sign = rd_shift[7];  end
      2'd1: begin strb8 = 8'h03; keep = DATA_WIDTH'(16'hFFFF);      sign = rd_shift[15]; end
      2'd2: begin strb8 = 8'h0F; keep = DATA_WIDTH'(32'hFFFF_FFFF); sign = rd_shift[31]; end
      default: begin strb8 = 8'hFF; keep = '1; sign = 1'b0; end  // dword: never extended
    endcase
    if (uns_q) sign = 1'b0;
    // For a word on a 32-bit bus keep is all ones, so no extension happens.
    rd_ext = (rd_shift & keep) | (~keep & {DATA_WIDTH{sign}});
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
          else if (req_misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
          else begin
            // Without trapping, a misaligned access silently uses the size-aligned address.
            addr_d  = req_addr_aligned;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (bus_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // A response arriving in the last allowed cycle still wins over the timeout.
        if (bus_rvalid) begin
          err_d = bus_err;
          if (!wen_q && !bus_err) rdata_d = rd_ext;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------- outputs: decoded from state and latched fields only ----------------
  assign req_ready = (state_q == IDLE);
  assign bus_valid = (state_q == ADDR);
  assign bus_wen   = bus_valid & wen_q;
  assign bus_addr  = bus_valid ? {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_wdata = bus_wen ? wdata_sh : '0;
  assign bus_wstrb = bus_wen ? strb_sh : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Bench for ysyx_23060201_lsu: a 32-bit and a 64-bit instance share stimulus; a table of
// directed transactions runs through one task, plus hand sequences for backpressure,
// timeout, reset mid-transaction and the reset state.

module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;         // 0: observe 32-bit instance, 1: 64-bit instance
  logic        rv32 = 1'b0, rv64 = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_uns = 1'b0;
  logic        rsp_ready = 1'b0, bus_ready = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [63:0] bus_rdata = '0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_bus_valid, a_bus_wen;
  logic [31:0] a_rsp_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_wstrb;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_bus_valid, b_bus_wen;
  logic [63:0] b_rsp_rdata, b_bus_wdata;
  logic [31:0] b_bus_addr;
  logic [7:0]  b_bus_wstrb;

  ysyx_23060201_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(rv32), .req_ready(a_req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_size(req_size), .req_unsigned(req_uns),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .bus_valid(a_bus_valid), .bus_ready(bus_ready), .bus_wen(a_bus_wen), .bus_addr(a_bus_addr),
    .bus_wdata(a_bus_wdata), .bus_wstrb(a_bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata[31:0]), .bus_err(bus_err)
  );

  ysyx_23060201_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(8)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(rv64), .req_ready(b_req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_uns),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .bus_valid(b_bus_valid), .bus_ready(bus_ready), .bus_wen(b_bus_wen), .bus_addr(b_bus_addr),
    .bus_wdata(b_bus_wdata), .bus_wstrb(b_bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Observed outputs of the selected instance.
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_bus_valid, o_bus_wen;
  logic [63:0] o_rsp_rdata, o_bus_wdata;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_wstrb;
  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_bus_valid = sel ? b_bus_valid : a_bus_valid;
  assign o_bus_wen   = sel ? b_bus_wen   : a_bus_wen;
  assign o_rsp_rdata = sel ? b_rsp_rdata : {32'h0, a_rsp_rdata};
  assign o_bus_wdata = sel ? b_bus_wdata : {32'h0, a_bus_wdata};
  assign o_bus_addr  = sel ? b_bus_addr  : a_bus_addr;
  assign o_bus_wstrb = sel ? b_bus_wstrb : {4'h0, a_bus_wstrb};

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rd;      // bus_rdata returned by memory
    logic        berr;    // bus_err returned by memory
    logic        bus;     // a bus transaction is expected
    logic [31:0] eaddr;
    logic [63:0] ewdata;
    logic [7:0]  estrb;
    logic [63:0] erdata;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  // One transaction with a zero-wait memory: checks bus fields in T1, rsp in T3 exactly
  // (or in T1 when no bus transaction is expected).
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    sel = v.sel;
    #1;
    chk({t, ".req_ready"}, o_req_ready, 1);
    req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata; req_size = v.size; req_uns = v.uns;
    if (v.sel) rv64 = 1'b1; else rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0; rv64 = 1'b0;
    if (v.bus) begin
      chk({t, ".bus_valid"}, o_bus_valid, 1);
      chk({t, ".bus_wen"},   o_bus_wen, v.wen);
      chk({t, ".bus_addr"},  o_bus_addr, v.eaddr);
      chk({t, ".bus_wdata"}, o_bus_wdata, v.ewdata);
      chk({t, ".bus_wstrb"}, o_bus_wstrb, v.estrb);
      chk({t, ".req_ready_busy"}, o_req_ready, 0);
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      chk({t, ".bus_valid_drop"}, o_bus_valid, 0);
      chk({t, ".rsp_early"}, o_rsp_valid, 0);
      bus_rvalid = 1'b1; bus_rdata = v.rd; bus_err = v.berr;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_err = 1'b0;
    end else begin
      chk({t, ".no_bus"}, o_bus_valid, 0);
    end
    chk({t, ".rsp_valid"}, o_rsp_valid, 1);
    chk({t, ".rsp_rdata"}, o_rsp_rdata, v.erdata);
    chk({t, ".rsp_err"},   o_rsp_err, v.eerr);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({t, ".rsp_done"}, o_rsp_valid, 0);
    chk({t, ".req_ready_again"}, o_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic ok;

    //                 sel   wen   addr          wdata                  sz    uns   rd                     berr  bus   eaddr         ewdata                 estrb  erdata                 eerr
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h80000004, 64'h0,                 2'd2, 1'b0, 64'hDEADBEEF,          1'b0, 1'b1, 32'h80000004, 64'h0,                 8'h0,  64'hDEADBEEF,          1'b0}); // LW
    tbl.push_back(vec_t'{1'b0, 1'b1, 32'h80000003, 64'hA5,                2'd0, 1'b0, 64'hFFFFFFFF,          1'b0, 1'b1, 32'h80000000, 64'hA5000000,          8'h8,  64'h0,                 1'b0}); // SB
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h80000003, 64'h0,                 2'd0, 1'b0, 64'hA5000000,          1'b0, 1'b1, 32'h80000000, 64'h0,                 8'h0,  64'hFFFFFFA5,          1'b0}); // LB
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h80000003, 64'h0,                 2'd0, 1'b1, 64'hA5000000,          1'b0, 1'b1, 32'h80000000, 64'h0,                 8'h0,  64'h000000A5,          1'b0}); // LBU
    tbl.push_back(vec_t'{1'b0, 1'b1, 32'h00002002, 64'h1234,              2'd1, 1'b0, 64'h0,                 1'b0, 1'b1, 32'h00002000, 64'h12340000,          8'hC,  64'h0,                 1'b0}); // SH
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00002002, 64'h0,                 2'd1, 1'b0, 64'h80017FFF,          1'b0, 1'b1, 32'h00002000, 64'h0,                 8'h0,  64'hFFFF8001,          1'b0}); // LH upper
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00002002, 64'h0,                 2'd1, 1'b1, 64'h80017FFF,          1'b0, 1'b1, 32'h00002000, 64'h0,                 8'h0,  64'h00008001,          1'b0}); // LHU upper
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00002000, 64'h0,                 2'd1, 1'b0, 64'h80017FFF,          1'b0, 1'b1, 32'h00002000, 64'h0,                 8'h0,  64'h00007FFF,          1'b0}); // LH lower
    tbl.push_back(vec_t'{1'b0, 1'b1, 32'h00003000, 64'hCAFEF00D,          2'd2, 1'b0, 64'h0,                 1'b0, 1'b1, 32'h00003000, 64'hCAFEF00D,          8'hF,  64'h0,                 1'b0}); // SW
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00003000, 64'h0,                 2'd2, 1'b0, 64'h00001111,          1'b1, 1'b1, 32'h00003000, 64'h0,                 8'h0,  64'h0,                 1'b1}); // LW bus error
    tbl.push_back(vec_t'{1'b0, 1'b1, 32'h00003004, 64'h77,                2'd0, 1'b0, 64'h0,                 1'b1, 1'b1, 32'h00003004, 64'h77,                8'h1,  64'h0,                 1'b1}); // SB bus error
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00000100, 64'h0,                 2'd3, 1'b0, 64'h0,                 1'b0, 1'b0, 32'h0,        64'h0,                 8'h0,  64'h0,                 1'b1}); // LD illegal on 32
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00000010, 64'h0,                 2'd0, 1'b0, 64'h00000080,          1'b0, 1'b1, 32'h00000010, 64'h0,                 8'h0,  64'hFFFFFF80,          1'b0}); // LB lane 0
`ifdef YSYX_23060201_LSU_MISALIGN_TRAP_EN
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00001001, 64'h0,                 2'd1, 1'b0, 64'hAABBCCDD,          1'b0, 1'b0, 32'h0,        64'h0,                 8'h0,  64'h0,                 1'b1}); // LH misaligned
    tbl.push_back(vec_t'{1'b0, 1'b1, 32'h00001002, 64'h11223344,          2'd2, 1'b0, 64'h0,                 1'b0, 1'b0, 32'h0,        64'h0,                 8'h0,  64'h0,                 1'b1}); // SW misaligned
`else
    tbl.push_back(vec_t'{1'b0, 1'b0, 32'h00001001, 64'h0,                 2'd1, 1'b0, 64'hAABBCCDD,          1'b0, 1'b1, 32'h00001000, 64'h0,                 8'h0,  64'hFFFFCCDD,          1'b0}); // LH misaligned
    tbl.push_back(vec_t'{1'b0, 1'b1, 32'h00001002, 64'h11223344,          2'd2, 1'b0, 64'h0,                 1'b0, 1'b1, 32'h00001000, 64'h11223344,          8'hF,  64'h0,                 1'b0}); // SW misaligned
`endif
    tbl.push_back(vec_t'{1'b1, 1'b0, 32'h00000008, 64'h0,                 2'd3, 1'b0, 64'h0123456789ABCDEF,  1'b0, 1'b1, 32'h00000008, 64'h0,                 8'h0,  64'h0123456789ABCDEF,  1'b0}); // LD 64
    tbl.push_back(vec_t'{1'b1, 1'b0, 32'h0000000C, 64'h0,                 2'd2, 1'b0, 64'h89ABCDEF01234567,  1'b0, 1'b1, 32'h00000008, 64'h0,                 8'h0,  64'hFFFFFFFF89ABCDEF,  1'b0}); // LW 64 upper
    tbl.push_back(vec_t'{1'b1, 1'b0, 32'h0000000C, 64'h0,                 2'd2, 1'b1, 64'h89ABCDEF01234567,  1'b0, 1'b1, 32'h00000008, 64'h0,                 8'h0,  64'h0000000089ABCDEF,  1'b0}); // LWU 64
    tbl.push_back(vec_t'{1'b1, 1'b1, 32'h0000000F, 64'h5A,                2'd0, 1'b0, 64'h0,                 1'b0, 1'b1, 32'h00000008, 64'h5A00000000000000,  8'h80, 64'h0,                 1'b0}); // SB 64
    tbl.push_back(vec_t'{1'b1, 1'b1, 32'h00000010, 64'h1122334455667788,  2'd3, 1'b0, 64'h0,                 1'b0, 1'b1, 32'h00000010, 64'h1122334455667788,  8'hFF, 64'h0,                 1'b0}); // SD 64

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.req_ready", o_req_ready, 1);
    chk("rst.rsp_valid", o_rsp_valid, 0);
    chk("rst.rsp_err",   o_rsp_err, 0);
    chk("rst.rsp_rdata", o_rsp_rdata, 0);
    chk("rst.bus_valid", o_bus_valid, 0);
    chk("rst.bus_wen",   o_bus_wen, 0);
    chk("rst.bus_addr",  o_bus_addr, 0);
    chk("rst.bus_wdata", o_bus_wdata, 0);
    chk("rst.bus_wstrb", o_bus_wstrb, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Backpressure: bus_ready low 4 cycles, rsp_ready low 3 cycles; stray bus_rvalid in ADDR.
    @(negedge clk);
    sel = 1'b0;
    req_wen = 1'b0; req_addr = 32'h4004; req_wdata = '0; req_size = 2'd2; req_uns = 1'b0;
    rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid = 1'b1; bus_rdata = 64'hBAD0BAD0;
      if (!(o_bus_valid && !o_bus_wen && o_bus_addr == 32'h4004 && o_bus_wstrb == 8'h0 &&
            !o_req_ready && !o_rsp_valid)) ok = 1'b0;
      @(negedge clk);
    end
    bus_rvalid = 1'b0;
    chk("bp.bus_stable", ok, 1);
    chk("bp.bus_valid_held", o_bus_valid, 1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h13579BDF;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = '0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!(o_rsp_valid && o_rsp_rdata == 64'h13579BDF && !o_rsp_err && !o_req_ready &&
            !o_bus_valid)) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp.rsp_stable", ok, 1);
    chk("bp.rsp_rdata", o_rsp_rdata, 64'h13579BDF);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.single_txn", o_rsp_valid, 0);

    // Timeout (TIMEOUT=8): response 9 cycles after entering DATA; late bus_rvalid ignored.
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h5000; req_size = 2'd2; req_uns = 1'b0;
    rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to.cycles", n, 9);
    chk("to.rsp_err", o_rsp_err, 1);
    chk("to.rsp_rdata", o_rsp_rdata, 0);
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = '0;
    chk("to.late_err", o_rsp_err, 1);
    chk("to.late_rdata", o_rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("to.idle_rvalid", o_rsp_valid, 0);
    run_vec(tbl[0], 100);

    // Reset while in DATA: outputs return to reset values at once; later rvalid ignored.
    @(negedge clk);
    sel = 1'b0;
    req_wen = 1'b1; req_addr = 32'h6000; req_wdata = 64'h12345678; req_size = 2'd2;
    rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst.req_ready", o_req_ready, 1);
    chk("mrst.bus_valid", o_bus_valid, 0);
    chk("mrst.rsp_valid", o_rsp_valid, 0);
    chk("mrst.bus_wstrb", o_bus_wstrb, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    ok = !o_rsp_valid;
    @(negedge clk);
    if (o_rsp_valid || !o_req_ready) ok = 1'b0;
    chk("mrst.no_rsp", ok, 1);
    run_vec(tbl[2], 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
